// File: rtl/regfile_sb.sv
// Parametrised register file with pending-write scoreboard.
// Two combinational read ports, one write port, optional R0 and bypass.
module regfile_sb #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 3,
  parameter int ZERO_R0 = 0,
  parameter int BYPASS  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] writenum,
  input  logic              write,
  input  logic [ADDR_W-1:0] readnum1,
  input  logic [ADDR_W-1:0] readnum2,
  input  logic              reserve,
  input  logic [ADDR_W-1:0] reservenum,
  output logic [DATA_W-1:0] data_out1,
  output logic [DATA_W-1:0] data_out2,
  output logic              busy1,
  output logic              busy2,
  output logic              any_busy
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam bit ZR    = (ZERO_R0 != 0);
  localparam bit BP    = (BYPASS != 0);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pend;
  logic [DEPTH-1:0]  pend_nxt;

  logic wr_ok;
  logic rs_ok;
  logic zero1;
  logic zero2;
  logic hit1;
  logic hit2;
  logic fwd1;
  logic fwd2;

  assign wr_ok = write & ~(ZR & (writenum == '0));
  assign rs_ok = reserve & ~(ZR & (reservenum == '0));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_ok) begin
      regs[writenum] <= data_in;
    end
  end

  // Reserve applied after the clear: a new producer wins over a retiring one.
  always_comb begin
    pend_nxt = pend;
    if (write) begin
      pend_nxt[writenum] = 1'b0;
    end
    if (rs_ok) begin
      pend_nxt[reservenum] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend <= '0;
    end else begin
      pend <= pend_nxt;
    end
  end

  assign zero1 = ZR & (readnum1 == '0);
  assign zero2 = ZR & (readnum2 == '0);
  assign hit1  = BP & write & (writenum == readnum1);
  assign hit2  = BP & write & (writenum == readnum2);
  assign fwd1  = hit1 & ~reset & ~zero1;
  assign fwd2  = hit2 & ~reset & ~zero2;

  always_comb begin
    data_out1 = regs[readnum1];
    unique case (1'b1)
      zero1:   data_out1 = '0;
      fwd1:    data_out1 = data_in;
      default: data_out1 = regs[readnum1];
    endcase
  end

  always_comb begin
    data_out2 = regs[readnum2];
    unique case (1'b1)
      zero2:   data_out2 = '0;
      fwd2:    data_out2 = data_in;
      default: data_out2 = regs[readnum2];
    endcase
  end

  assign busy1    = pend[readnum1] & ~hit1 & ~zero1;
  assign busy2    = pend[readnum2] & ~hit2 & ~zero2;
  assign any_busy = |pend;

endmodule
